// File: rtl/filt_sched.sv
// -----------------------------------------------------------------------------
// filt_sched
//   Sample scheduler in front of the filters block. Incoming XADC samples are
//   queued in a small FIFO. One sample at a time is handed to the filters with
//   a filt_start pulse. The scheduler then waits for filt_done and returns the
//   filtered result as a one-cycle out_valid strobe. The filter select is
//   latched only when a new sample is issued. A watchdog abandons a sample
//   whose done never arrives.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   adc_valid      sample strobe from XADC capture
//   adc_data       sample
//   sel_req        requested filter: 00 LPF, 01 HPF, 10 BPF, 11 bypass
//   filt_start     one-cycle start pulse to the filters
//   filt_val       sample to the filters, held from one start to the next
//   filt_select    select to the filters, updated only when a sample is issued
//   filt_done      done from the filters (stuck at 1 in bypass)
//   filt_result    filters result register
//   out_valid      one-cycle result strobe
//   out_data       filtered sample, held until the next out_valid
//   busy           scheduler active or samples still queued
//   ovf_cnt        saturating count of samples dropped on a full FIFO
//   timeout_err    sticky, set when the watchdog abandons a sample
// -----------------------------------------------------------------------------
module filt_sched #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT        = 255,
    parameter int OVF_CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      adc_valid,
    input  logic [XADC_DATA_SIZE-1:0] adc_data,
    input  logic [1:0]                sel_req,
    output logic                      filt_start,
    output logic [XADC_DATA_SIZE-1:0] filt_val,
    output logic [1:0]                filt_select,
    input  logic                      filt_done,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    output logic                      out_valid,
    output logic [XADC_DATA_SIZE-1:0] out_data,
    output logic                      busy,
    output logic [OVF_CNT_W-1:0]      ovf_cnt,
    output logic                      timeout_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPT
    } state_t;

    state_t                    state;
    logic [TMR_W-1:0]          timer;

    logic [XADC_DATA_SIZE-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr;
    logic [FIFO_AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_n;

    logic                      full;
    logic                      pop;
    logic                      push_ok;
    logic                      drop;

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = (state == S_IDLE) && (count != '0);
    assign push_ok = adc_valid && (!full || pop);
    assign drop    = adc_valid && full && !pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_n = count;
        if (push_ok && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_n = count - CNT_W'(1);
        end
    end

    // NOTE: the sample storage has no reset; the occupancy count alone decides
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= adc_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            count <= count_n;
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (drop && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

    // Scheduler FSM; every output is a register. busy is loaded with the value
    // that matches the state and FIFO occupancy being entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            timer       <= '0;
            filt_start  <= 1'b0;
            filt_val    <= '0;
            filt_select <= 2'b00;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            filt_start <= 1'b0;
            out_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= (count_n != '0);
                    if (pop) begin
                        filt_val    <= mem[rd_ptr];
                        filt_select <= sel_req;
                        filt_start  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    // filt_done is not looked at here: the filters may still
                    // be showing the previous sample's done.
                    timer <= '0;
                    busy  <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    busy <= 1'b1;
                    if (filt_done) begin
                        state <= S_CAPT;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        // Count reaches TIMEOUT on this cycle: abandon sample.
                        timeout_err <= 1'b1;
                        busy        <= (count_n != '0);
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_CAPT: begin
                    // The filters register their result on done, so it is
                    // read one cycle after done was seen.
                    out_data  <= filt_result;
                    out_valid <= 1'b1;
                    busy      <= (count_n != '0);
                    state     <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filt_sched.sv
// -----------------------------------------------------------------------------
// tb_filt_sched
//   Self-checking bench for filt_sched. A behavioural filters model answers
//   filt_start with a programmable latency, never answers (stalled), or acts
//   as bypass with done stuck high. Expected results are queued from the
//   sample and the select the bench requested; a monitor compares each
//   out_valid against the head of that queue.
// -----------------------------------------------------------------------------
module tb_filt_sched;

    localparam int DW = 16;

    localparam int M_LAT    = 0;
    localparam int M_STALL  = 1;
    localparam int M_BYPASS = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic [1:0]    sel_req;
    logic          filt_start;
    logic [DW-1:0] filt_val;
    logic [1:0]    filt_select;
    logic          filt_done;
    logic [DW-1:0] filt_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [15:0]   ovf_cnt;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    int mode = M_LAT;
    int lat  = 3;

    logic [DW-1:0] exp_q[$];
    int            exp_ovf;

    filt_sched dut (
        .clk         (clk),
        .rstn        (rstn),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .sel_req     (sel_req),
        .filt_start  (filt_start),
        .filt_val    (filt_val),
        .filt_select (filt_select),
        .filt_done   (filt_done),
        .filt_result (filt_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .ovf_cnt     (ovf_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Filter transfer functions as seen at the output of the filters block.
    function automatic logic [DW-1:0] ref_filt(input logic [DW-1:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return v >> 1;
            2'b01:   return ~v;
            2'b10:   return v + 16'h0101;
            default: return v;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Filters model.
    initial begin : filters_model
        bit            pending;
        int            cnt;
        logic [DW-1:0] m_val;
        logic [1:0]    m_sel;
        pending     = 1'b0;
        cnt         = 0;
        m_val       = '0;
        m_sel       = 2'b00;
        filt_done   = 1'b0;
        filt_result = '0;
        forever begin
            @(posedge clk);
            #1;
            filt_done = 1'b0;
            if (rstn !== 1'b1) begin
                pending = 1'b0;
            end else if (mode == M_BYPASS) begin
                filt_done   = 1'b1;
                filt_result = filt_val;
            end else if (filt_start === 1'b1) begin
                pending = 1'b1;
                cnt     = lat;
                m_val   = filt_val;
                m_sel   = filt_select;
            end else if (pending && mode == M_LAT) begin
                if (cnt <= 1) begin
                    filt_done   = 1'b1;
                    filt_result = ref_filt(m_val, m_sel);
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Result monitor.
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Drive adc_valid/adc_data for the next rising edge.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        adc_valid = v;
        adc_data  = d;
    endtask

    // Single-cycle push; returns 1 time unit after the sampling edge.
    task automatic push(input logic [DW-1:0] d);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = d;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (filt_start === 1'b1) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, exp_q.size(), 0);
    endtask

    logic [DW-1:0] d;
    logic [1:0]    s;
    int            n;
    int            occ;
    logic          seen;

    initial begin : stimulus
        rstn      = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        sel_req   = 2'b00;
        exp_ovf   = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_filt_start", filt_start, 0);
        check("rst_filt_val", filt_val, 0);
        check("rst_filt_select", filt_select, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Bypass latency: push at edge E, start after E+1, result after E+4.
        mode    = M_BYPASS;
        sel_req = 2'b11;
        repeat (2) @(posedge clk);
        exp_q.push_back(16'h1234);
        push(16'h1234);
        check("byp_start_e0", filt_start, 0);
        check("byp_busy", busy, 1);
        @(posedge clk); #1;
        check("byp_start_e1", filt_start, 1);
        check("byp_filt_val", filt_val, 16'h1234);
        check("byp_filt_select", filt_select, 2'b11);
        @(posedge clk); #1;
        check("byp_start_e2", filt_start, 0);
        @(posedge clk); #1;
        check("byp_valid_e3", out_valid, 0);
        @(posedge clk); #1;
        check("byp_valid_e4", out_valid, 1);
        check("byp_data_e4", out_data, 16'h1234);
        @(posedge clk); #1;
        check("byp_valid_e5", out_valid, 0);
        check("byp_data_held", out_data, 16'h1234);
        check("byp_idle_busy", busy, 0);

        // Select change while a sample waits for done.
        mode    = M_LAT;
        lat     = 20;
        sel_req = 2'b00;
        repeat (2) @(posedge clk);
        exp_q.push_back(ref_filt(16'h8421, 2'b00));
        push(16'h8421);
        wait_start("sel_start0");
        sel_req = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("sel_held_in_wait", filt_select, 2'b00);
        drain("sel_drain0");
        exp_q.push_back(ref_filt(16'h0F0F, 2'b01));
        push(16'h0F0F);
        wait_start("sel_start1");
        check("sel_applied", filt_select, 2'b01);
        drain("sel_drain1");

        // Random batches, never more than the FIFO can hold.
        for (int b = 0; b < 12; b++) begin
            s       = 2'($urandom_range(0, 3));
            n       = $urandom_range(1, 3);
            lat     = $urandom_range(1, 8);
            mode    = (s == 2'b11) ? M_BYPASS : M_LAT;
            sel_req = s;
            for (int k = 0; k < n; k++) begin
                d = 16'($urandom);
                exp_q.push_back(ref_filt(d, s));
                drive_cycle(1'b1, d);
            end
            drive_cycle(1'b0, '0);
            drain("rnd_drain");
            @(posedge clk); #1;
            check("rnd_busy_idle", busy, 0);
            check("rnd_ovf", ovf_cnt, exp_ovf);
        end

        // Burst while one sample is stalled in flight: 4 queue, rest drop.
        mode    = M_STALL;
        lat     = 3;
        sel_req = 2'b10;
        repeat (2) @(posedge clk);
        d = 16'hA000;
        exp_q.push_back(ref_filt(d, 2'b10));
        push(d);
        wait_start("burst_start");
        occ = 0;
        for (int k = 0; k < 6; k++) begin
            d = 16'hB000 + 16'(k);
            if (occ < 4) begin
                exp_q.push_back(ref_filt(d, 2'b10));
                occ++;
            end else begin
                exp_ovf++;
            end
            drive_cycle(1'b1, d);
        end
        drive_cycle(1'b0, '0);
        check("burst_ovf", ovf_cnt, exp_ovf);
        check("burst_ovf_is_2", ovf_cnt, 2);
        check("burst_busy", busy, 1);
        mode = M_LAT;

        // Push into the full FIFO on the cycle the head is popped.
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("full_first_result", seen, 1);
        d = 16'hC0DE;
        exp_q.push_back(ref_filt(d, 2'b10));
        adc_valid = 1'b1;
        adc_data  = d;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        check("full_pop_start", filt_start, 1);
        check("full_pop_ovf", ovf_cnt, exp_ovf);
        drain("burst_drain");
        check("burst_ovf_final", ovf_cnt, exp_ovf);

        // Watchdog: done never arrives for the first sample.
        mode    = M_STALL;
        sel_req = 2'b00;
        repeat (2) @(posedge clk);
        push(16'h1111);
        wait_start("to_start_a");
        d = 16'h2222;
        exp_q.push_back(ref_filt(d, 2'b00));
        push(d);
        repeat (254) @(posedge clk);
        #1;
        check("to_not_yet", timeout_err, 0);
        @(posedge clk); #1;
        check("to_set", timeout_err, 1);
        check("to_no_valid", out_valid, 0);
        @(posedge clk); #1;
        check("to_next_start", filt_start, 1);
        check("to_next_val", filt_val, d);
        mode = M_LAT;
        lat  = 2;
        drain("to_drain");
        check("to_sticky", timeout_err, 1);

        // Asynchronous reset while waiting for done.
        mode = M_STALL;
        repeat (2) @(posedge clk);
        push(16'h3333);
        wait_start("ar_start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_filt_start", filt_start, 0);
        check("ar_filt_val", filt_val, 0);
        check("ar_filt_select", filt_select, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        check("ar_busy", busy, 0);
        check("ar_ovf_cnt", ovf_cnt, 0);
        check("ar_timeout_err", timeout_err, 0);
        exp_ovf = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        mode = M_LAT;
        lat  = 4;
        sel_req = 2'b01;
        repeat (2) @(posedge clk);
        d = 16'h5A5A;
        exp_q.push_back(ref_filt(d, 2'b01));
        push(d);
        wait_start("ar_after_start");
        check("ar_after_select", filt_select, 2'b01);
        drain("ar_after_drain");
        @(posedge clk); #1;
        check("ar_after_busy", busy, 0);
        check("ar_after_ovf", ovf_cnt, exp_ovf);
        check("ar_after_timeout", timeout_err, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
